// File: rtl/clk_div_prog.sv
// ---------------------------------------------------------------------------------------------
// clk_div_prog
//
// Programmable integer clock divider. Derives a slow clock (clk_o) and an optional one-cycle
// rising-edge strobe (tick_o) from clk_i. Both come straight from flops. Any divisor from 2 to
// 2^DivWidth-1 is supported, odd ones included. Start and stop are glitch-free, and the divisor
// is updated through a valid/ready handshake.
//
// Parameters
//   DivWidth    width of the divisor and period counter (2..32)
//   DefaultDiv  divisor loaded at reset (2 .. 2^DivWidth-1, checked at elaboration)
//
// Ports
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   en_i         run request (level)
//   div_i        requested divisor; values below 2 are stored as 2
//   div_valid_i  div_i is valid
//   div_ready_o  a new divisor can be accepted (no divisor pending)
//   clk_o        divided clock; high phase is ceil(div/2) cycles, low phase floor(div/2)
//   tick_o       one-cycle pulse coincident with each rising edge of clk_o
//   active_o     divider is running or draining its final period
//
// Build option
//   CLK_DIV_PROG_TICK_EN  when defined, tick_o is driven by a flop; otherwise it is tied to 0
//                         and no tick flop exists.
// ---------------------------------------------------------------------------------------------
module clk_div_prog #(
  parameter int unsigned DivWidth   = 16,
  parameter int unsigned DefaultDiv = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic [DivWidth-1:0] div_i,
  input  logic                div_valid_i,
  output logic                div_ready_o,
  output logic                clk_o,
  output logic                tick_o,
  output logic                active_o
);

  // -------------------------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // -------------------------------------------------------------------------------------------
  if ((DivWidth < 2) || (DivWidth > 32)) begin : g_bad_width
    $fatal(1, "clk_div_prog: DivWidth must be in 2..32");
  end
  if ((DefaultDiv < 2) || (longint'(DefaultDiv) >= (longint'(1) << DivWidth))) begin : g_bad_def
    $fatal(1, "clk_div_prog: DefaultDiv must be >= 2 and < 2^DivWidth");
  end

  localparam logic [DivWidth-1:0] One    = DivWidth'(1);
  localparam logic [DivWidth-1:0] Two    = DivWidth'(2);
  localparam logic [DivWidth-1:0] DefDiv = DivWidth'(DefaultDiv);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  // -------------------------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------------------------
  logic [1:0]          state_q, state_d;
  logic [DivWidth-1:0] cnt_q, cnt_d;
  logic                clk_q, clk_d;
  logic [DivWidth-1:0] div_q;
  logic [DivWidth-1:0] pend_q;
  logic                pend_vld_q;

  // -------------------------------------------------------------------------------------------
  // Period arithmetic (all DivWidth bits; cnt_q + 1 cannot overflow since cnt_q < div_q)
  // -------------------------------------------------------------------------------------------
  logic [DivWidth-1:0] w_half;
  logic [DivWidth-1:0] w_high;
  logic [DivWidth-1:0] w_last;
  logic [DivWidth-1:0] w_cnt_inc;
  logic                w_wrap;
  logic                w_high_nxt;
  logic                w_accept;
  logic                w_apply;
  logic [DivWidth-1:0] w_div_clamp;

  assign w_half      = div_q >> 1;
  assign w_high      = div_q - w_half;        // ceil(div/2): odd divisors get the longer high
  assign w_last      = div_q - One;
  assign w_cnt_inc   = cnt_q + One;
  assign w_wrap      = (cnt_q == w_last);
  assign w_high_nxt  = (w_cnt_inc < w_high);

  assign w_accept    = div_valid_i & ~pend_vld_q;
  assign w_div_clamp = (div_i < Two) ? Two : div_i;

  // -------------------------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clk_d   = clk_q;
    w_apply = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d   = '0;
        clk_d   = 1'b0;
        // A divisor pending while idle is taken on the very next edge.
        w_apply = pend_vld_q;
        if (en_i) begin
          state_d = StRun;
          clk_d   = 1'b1;
        end
      end

      StRun: begin
        if (w_wrap) begin
          cnt_d   = '0;
          w_apply = pend_vld_q;
          if (en_i) begin
            clk_d = 1'b1;
          end else begin
            // The low phase has just completed, so stopping here leaves no runt.
            clk_d   = 1'b0;
            state_d = StIdle;
          end
        end else begin
          cnt_d = w_cnt_inc;
          clk_d = w_high_nxt;
          if (!en_i) begin
            state_d = StDrain;
          end
        end
      end

      StDrain: begin
        if (w_wrap) begin
          cnt_d   = '0;
          clk_d   = 1'b0;
          w_apply = pend_vld_q;
          state_d = StIdle;
        end else begin
          cnt_d = w_cnt_inc;
          clk_d = w_high_nxt;
          // Returning to RUN does not disturb the period in progress.
          if (en_i) begin
            state_d = StRun;
          end
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        clk_d   = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      clk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clk_q   <= clk_d;
    end
  end

  // Divisor handshake. Accept and apply can never coincide: accept needs pend_vld_q low and
  // apply needs it high. A divisor accepted on a wrap edge is therefore held for the next wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q      <= DefDiv;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      if (w_accept) begin
        pend_q     <= w_div_clamp;
        pend_vld_q <= 1'b1;
      end else if (w_apply) begin
        div_q      <= pend_q;
        pend_vld_q <= 1'b0;
      end
    end
  end

`ifdef CLK_DIV_PROG_TICK_EN
  logic tick_q;
  logic w_tick_d;

  // clk_d only rises at the start of a period, so a rising edge marks each tick.
  assign w_tick_d = clk_d & ~clk_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= w_tick_d;
    end
  end

  assign tick_o = tick_q;
`else
  assign tick_o = 1'b0;
`endif

  // -------------------------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------------------------
  assign clk_o       = clk_q;
  assign active_o    = (state_q != StIdle);
  assign div_ready_o = ~pend_vld_q;

  // -------------------------------------------------------------------------------------------
  // Invariants
  // -------------------------------------------------------------------------------------------
  a_cnt_in_range: assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_q < div_q);
  a_div_min:      assert property (@(posedge clk_i) disable iff (!rst_ni) div_q >= Two);
  a_idle_quiet:   assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   (state_q == StIdle) |-> (!clk_q && (cnt_q == '0)));
  a_state_legal:  assert property (@(posedge clk_i) disable iff (!rst_ni) state_q != 2'd3);
  a_pend_stable:  assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   pend_vld_q |=> (!pend_vld_q || $stable(pend_q)));
`ifdef CLK_DIV_PROG_TICK_EN
  a_tick_high:    assert property (@(posedge clk_i) disable iff (!rst_ni) tick_o |-> clk_o);
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// ---------------------------------------------------------------------------------------------
// tb_clk_div_prog
//
// Self-checking bench for clk_div_prog (DivWidth=16, DefaultDiv=4). A directed vector table
// drives en/div/valid per cycle and lists the hand-computed outputs after that clock edge;
// a hand-written sequence covers asynchronous reset mid-operation. Expected tick values in the
// table assume the tick flop is built and are masked to 0 when it is not.
// ---------------------------------------------------------------------------------------------
module tb_clk_div_prog;

`ifdef CLK_DIV_PROG_TICK_EN
  localparam bit TickEn = 1'b1;
`else
  localparam bit TickEn = 1'b0;
`endif

  logic        clk_i;
  logic        rst_ni;
  logic        en_i;
  logic [15:0] div_i;
  logic        div_valid_i;
  logic        div_ready_o;
  logic        clk_o;
  logic        tick_o;
  logic        active_o;

  int n_checks = 0;
  int n_fail   = 0;

  clk_div_prog #(
    .DivWidth   (16),
    .DefaultDiv (4)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en_i        (en_i),
    .div_i       (div_i),
    .div_valid_i (div_valid_i),
    .div_ready_o (div_ready_o),
    .clk_o       (clk_o),
    .tick_o      (tick_o),
    .active_o    (active_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        en;
    logic        vld;
    logic [15:0] div;
    logic        clk;
    logic        tick;
    logic        act;
    logic        rdy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic en, input logic vld, input logic [15:0] div,
                              input logic clk, input logic tick, input logic act,
                              input logic rdy);
    vec_t v;
    v.en = en; v.vld = vld; v.div = div;
    v.clk = clk; v.tick = tick; v.act = act; v.rdy = rdy;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_clk, input logic e_tick,
                            input logic e_act, input logic e_rdy);
    check({tag, " clk_o"},       clk_o,       e_clk);
    check({tag, " tick_o"},      tick_o,      e_tick & TickEn);
    check({tag, " active_o"},    active_o,    e_act);
    check({tag, " div_ready_o"}, div_ready_o, e_rdy);
  endtask

  initial begin
    // ---------------------------------------------------------------- vector table
    // en vld div   | clk tick act rdy   (outputs after the edge that samples the inputs)
    // Default divisor 4: 1,1,0,0 repeating, start one edge after en sampled.
    add(1, 0, 0,   1, 1, 1, 1);  // 1  start
    add(1, 0, 0,   1, 0, 1, 1);
    add(1, 0, 0,   0, 0, 1, 1);
    add(1, 0, 0,   0, 0, 1, 1);
    add(1, 0, 0,   1, 1, 1, 1);  // 5  wrap
    // Divisor 5 accepted mid-period; ready low until the wrap edge plus one.
    add(1, 1, 5,   1, 0, 1, 0);  // 6  accept
    add(1, 0, 0,   0, 0, 1, 0);
    add(1, 0, 0,   0, 0, 1, 0);
    add(1, 0, 0,   1, 1, 1, 1);  // 9  wrap, div=5 applied
    add(1, 0, 0,   1, 0, 1, 1);
    add(1, 0, 0,   1, 0, 1, 1);
    add(1, 0, 0,   0, 0, 1, 1);
    add(1, 0, 0,   0, 0, 1, 1);
    // Divisor 3 offered on a wrap edge: held for one more full 5-cycle period.
    add(1, 1, 3,   1, 1, 1, 0);  // 14 wrap + accept
    add(1, 0, 0,   1, 0, 1, 0);
    add(1, 0, 0,   1, 0, 1, 0);
    add(1, 0, 0,   0, 0, 1, 0);
    add(1, 0, 0,   0, 0, 1, 0);
    add(1, 0, 0,   1, 1, 1, 1);  // 19 wrap, div=3 applied
    // Divisor 0 clamps to 2.
    add(1, 1, 0,   1, 0, 1, 0);  // 20 accept
    add(1, 0, 0,   0, 0, 1, 0);
    add(1, 0, 0,   1, 1, 1, 1);  // 22 wrap, div=2
    add(1, 0, 0,   0, 0, 1, 1);
    add(1, 0, 0,   1, 1, 1, 1);
    // Divisor 1 clamps to 2 as well.
    add(1, 1, 1,   0, 0, 1, 0);  // 25 accept
    add(1, 0, 0,   1, 1, 1, 1);  // 26 wrap, div=2
    add(1, 0, 0,   0, 0, 1, 1);
    // Divisor 6 accepted on a wrap edge.
    add(1, 1, 6,   1, 1, 1, 0);  // 28
    add(1, 0, 0,   0, 0, 1, 0);
    add(1, 0, 0,   1, 1, 1, 1);  // 30 wrap, div=6
    add(1, 0, 0,   1, 0, 1, 1);  // cnt=1
    // en dropped at cnt=1: period completes 1,1,1,0,0,0 then stops.
    add(0, 0, 0,   1, 0, 1, 1);  // 32 drain
    add(0, 0, 0,   0, 0, 1, 1);
    add(0, 0, 0,   0, 0, 1, 1);
    add(0, 0, 0,   0, 0, 1, 1);
    add(0, 0, 0,   0, 0, 0, 1);  // 36 wrap -> idle
    add(0, 0, 0,   0, 0, 0, 1);
    add(0, 0, 0,   0, 0, 0, 1);
    // Restart, then re-raise en during drain: no interruption.
    add(1, 0, 0,   1, 1, 1, 1);  // 39
    add(1, 0, 0,   1, 0, 1, 1);
    add(0, 0, 0,   1, 0, 1, 1);  // 41 drain
    add(0, 0, 0,   0, 0, 1, 1);
    add(1, 0, 0,   0, 0, 1, 1);  // 43 back to run
    add(1, 0, 0,   0, 0, 1, 1);
    add(1, 0, 0,   1, 1, 1, 1);  // 45 wrap
    add(1, 0, 0,   1, 0, 1, 1);
    add(1, 0, 0,   1, 0, 1, 1);
    add(1, 0, 0,   0, 0, 1, 1);
    add(1, 0, 0,   0, 0, 1, 1);
    add(1, 0, 0,   0, 0, 1, 1);
    add(0, 0, 0,   0, 0, 0, 1);  // 51 en low on wrap -> idle directly
    // Divisor 7 accepted while idle: applied on the next edge.
    add(0, 1, 7,   0, 0, 0, 0);  // 52
    add(0, 0, 0,   0, 0, 0, 1);  // 53 applied
    add(1, 0, 0,   1, 1, 1, 1);  // 54 start, div=7: 1,1,1,1,0,0,0
    add(1, 0, 0,   1, 0, 1, 1);
    add(1, 0, 0,   1, 0, 1, 1);
    add(1, 0, 0,   1, 0, 1, 1);
    add(1, 0, 0,   0, 0, 1, 1);
    add(1, 0, 0,   0, 0, 1, 1);
    add(1, 0, 0,   0, 0, 1, 1);
    add(1, 0, 0,   1, 1, 1, 1);  // 61 wrap
    add(1, 1, 9,   1, 0, 1, 0);  // 62 divisor 9 pending, mid high phase

    // ---------------------------------------------------------------- reset state
    rst_ni      = 1'b0;
    en_i        = 1'b0;
    div_i       = '0;
    div_valid_i = 1'b0;
    #12;
    check_outs("reset", 0, 0, 0, 1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check_outs("idle after reset", 0, 0, 0, 1);

    // ---------------------------------------------------------------- table
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk_i);
      en_i        = vecs[i].en;
      div_valid_i = vecs[i].vld;
      div_i       = vecs[i].div;
      @(posedge clk_i); #1;
      check_outs($sformatf("vec%0d", i + 1), vecs[i].clk, vecs[i].tick, vecs[i].act,
                 vecs[i].rdy);
    end

    // ---------------------------------------------------------------- async reset mid-high
    @(negedge clk_i);
    div_valid_i = 1'b0;
    #1;
    check("pre-reset clk_o high", clk_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    check_outs("async reset", 0, 0, 0, 1);
    @(posedge clk_i); #1;
    check_outs("held in reset", 0, 0, 0, 1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    en_i   = 1'b0;
    @(posedge clk_i); #1;
    check_outs("idle after reset release", 0, 0, 0, 1);

    // Default divisor 4 is back and the lost pending 9 never appears.
    begin
      logic [7:0] exp_clk;
      logic [7:0] exp_tick;
      exp_clk  = 8'b1100_1100;
      exp_tick = 8'b1000_1000;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk_i);
        en_i = 1'b1;
        @(posedge clk_i); #1;
        check_outs($sformatf("post-reset div4 cyc%0d", k), exp_clk[7-k], exp_tick[7-k], 1'b1,
                   1'b1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Programmable integer clock divider generating a slow, flop-derived clock enable/clock (up to a few hundred Hz, relaxed jitter) from the system clock. It is the successor to the fixed even-only prescaler. It adds a runtime-programmable divisor, odd division, glitch-free start/stop, a valid/ready divisor-update handshake and an optional rising-edge tick pulse. It sits between the system clock domain and slow peripherals such as shift registers and display multiplexers.

## Interface
- `DivWidth`, default 16: width of the divisor and counter; maximum divisor is 2^DivWidth-1.
- `DefaultDiv`, default 4: divisor loaded at reset; must be >= 2 and < 2^DivWidth, otherwise elaboration is `$fatal`.
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `en_i`  in  1  run request; level-sensitive.
- `div_i`  in  DivWidth  requested divisor.
- `div_valid_i`  in  1  `div_i` valid.
- `div_ready_o`  out  1  divider can accept a new divisor.
- `clk_o`  out  1  divided clock, driven directly from a flop.
- `tick_o`  out  1  one-cycle pulse, coincident with each rising edge of `clk_o`.
- `active_o`  out  1  FSM not in IDLE.

## Operation
- Registers:
  - `div_q` holds the active divisor; resets to `DefaultDiv`.
  - `pend_q`/`pend_vld_q` hold the pending divisor.
  - `cnt_q` is DivWidth bits wide.
  - `clk_q` drives `clk_o`; `tick_q` drives `tick_o`.
  - State is one of IDLE, RUN, DRAIN.
- Divisor clamp: any accepted divisor < 2 is stored as 2.
- Duty cycle: high phase is H = div - (div>>1) cycles (ceil); low phase is div>>1 cycles. Odd divisors are therefore high one cycle longer.
- Counter and output in RUN/DRAIN:
  - If `cnt_q == div_q-1`, the period wraps: `cnt_q`<=0.
  - Otherwise `cnt_q`<=`cnt_q`+1 and `clk_q`<=(`cnt_q`+1 < H).
- IDLE:
  - `cnt_q`=0 and `clk_q`=0.
  - If `en_i`=1, go to RUN: `clk_q`<=1, `tick_q`<=1, `cnt_q`<=0.
- RUN:
  - At wrap, if `en_i`=1: `clk_q`<=1 and `tick_q`<=1.
  - If `en_i`=0 is sampled at any cycle, go to DRAIN without touching `cnt_q`/`clk_q` progression.
  - If `en_i`=0 coincides with wrap: `clk_q`<=0, go to IDLE directly.
- DRAIN:
  - The current period completes normally.
  - At wrap: `clk_q`<=0, `tick_q`<=0, go to IDLE.
  - If `en_i`=1 is sampled before wrap, return to RUN; the period continues with no glitch.
- No runt pulses: `clk_o` only ever stops after a complete low phase.
- Divisor handshake:
  - `div_ready_o` = ~`pend_vld_q`. A transfer occurs when `div_valid_i` & `div_ready_o`; the clamped value is stored in `pend_q`.
  - The pending value is applied to `div_q` at the next wrap (RUN/DRAIN), or on the next edge when in IDLE. `pend_vld_q` then clears, so `div_ready_o` is high again one cycle later.
  - A divisor accepted in the same cycle as a wrap is not applied at that wrap; it is applied at the following wrap.
- `tick_o` is high for exactly one cycle per rising edge of `clk_o`, otherwise 0.

## Timing
- All outputs are registered except `div_ready_o` and `active_o`, which are decoded from flops.
- Reset values: `clk_o`=0, `tick_o`=0, `active_o`=0, `div_ready_o`=1, `div_q`=`DefaultDiv`, `cnt_q`=0.
- Start latency: `en_i` sampled high in IDLE at edge n gives `clk_o`=1 and `tick_o`=1 after edge n.
- Period: exactly `div_q` cycles, measured rising-to-rising, for as long as RUN persists.
- Divisor change: the new period starts at the wrap edge following acceptance. The old period is never truncated.
- Reset mid-operation clears all state asynchronously; `clk_o` drops immediately and any pending divisor is lost.
- Arithmetic: all counter/H arithmetic is DivWidth bits. `cnt_q`+1 cannot overflow because `cnt_q` <= `div_q`-1 < 2^DivWidth-1.

## Configuration
- `CLK_DIV_PROG_TICK_EN`:
  - Defined: `tick_q` is implemented as specified.
  - Undefined: no tick flop is built and `tick_o` is tied to 0.
  - All other behaviour is identical in both cases.

## Test plan
- Reset, then `en_i`=1 with default divisor 4: `clk_o` pattern 1,1,0,0 repeats; `tick_o` pulses every 4 cycles; first rise one edge after `en_i` is sampled.
- `div_i`=5 accepted while running at 4: the current 4-cycle period completes, then pattern 1,1,1,0,0; `div_ready_o` is low for exactly the cycles until the wrap plus one.
- `div_i`=0 and `div_i`=1 accepted: the divisor clamps to 2; pattern 1,0 repeats.
- `en_i` dropped at `cnt_q`=1 with divisor 6: `clk_o` finishes high,high,high,low,low,low, then stays 0; `active_o` falls at the wrap. `en_i` re-raised during DRAIN: the period continues uninterrupted.
- `div_valid_i` held high on the same cycle as a wrap with `div_i`=3: the value is applied at the next wrap, not the current one.
- `rst_ni` asserted mid-high-phase: `clk_o`=0 immediately; after release the divisor is back to `DefaultDiv` and the FSM is in IDLE. With `CLK_DIV_PROG_TICK_EN` undefined, `tick_o` stays 0 in every scenario.
